// File: rtl/axi_ram_init_ctrl.sv
// Purpose: AXI4 master that fills main RAM with a fixed pattern using INCR bursts and optionally reads it back to verify it.
// Latency: busy one cycle after reset release; ideal-slave bursts take a few cycles more than BURST_BEATS; done/error assert the cycle after the final B/R handshake.
// Backpressure: one transaction outstanding; valids hold a stable payload until ready; outputs decode registered state only.
module axi_ram_init_ctrl #(
  parameter logic [31:0] RAM_SIZE     = 32'h10000,
  parameter int          BURST_BEATS  = 16,
  parameter int          ID_WIDTH     = 6,
  parameter logic [63:0] FILL_PATTERN = 64'h0,
  parameter bit          VERIFY       = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_init_done,
  output logic                o_init_error,
  output logic [31:0]         o_err_addr,
  // write address channel
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  // write data channel
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  // write response channel
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  // read address channel
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  // read data channel
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS * 8);
  localparam logic [8:0]  LAST_BEAT   = 9'(BURST_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAW,
    S_WDAT,
    S_WRSP,
    S_RAR,
    S_RDAT,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] addr, addr_n;
  logic [8:0]  beat, beat_n;
  logic        err_flag, err_flag_n;
  logic [31:0] err_addr, err_addr_n;

  logic [31:0] next_addr;
  logic        wrap;
  logic        beat_bad;

  // Only one transaction is ever in flight, so response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{i_bid, i_rid};

  assign next_addr = addr + BURST_BYTES;
  assign wrap      = (next_addr == RAM_SIZE);
  assign beat_bad  = (i_rresp != 2'b00) || (i_rdata != FILL_PATTERN);

  // State and datapath registers; reset kills any burst in flight without draining.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      addr     <= '0;
      beat     <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      beat     <= beat_n;
      err_flag <= err_flag_n;
      err_addr <= err_addr_n;
    end
  end

  // Next-state sequencing: fill pass, optional verify pass, then park in DONE.
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    beat_n     = beat;
    err_flag_n = err_flag;
    err_addr_n = err_addr;
    case (state)
      S_IDLE: begin
        addr_n  = '0;
        beat_n  = '0;
        state_n = S_WAW;
      end
      S_WAW: begin
        if (i_awready) state_n = S_WDAT;
      end
      S_WDAT: begin
        if (i_wready) begin
          if (beat == LAST_BEAT) begin
            beat_n  = '0;
            state_n = S_WRSP;
          end else begin
            beat_n = beat + 9'd1;
          end
        end
      end
      S_WRSP: begin
        if (i_bvalid) begin
          if (i_bresp != 2'b00) begin
            err_flag_n = 1'b1;
            err_addr_n = addr;
            state_n    = S_DONE;
          end else if (wrap) begin
            addr_n  = '0;
            state_n = VERIFY ? S_RAR : S_DONE;
          end else begin
            addr_n  = next_addr;
            state_n = S_WAW;
          end
        end
      end
      S_RAR: begin
        if (i_arready) state_n = S_RDAT;
      end
      S_RDAT: begin
        if (i_rvalid) begin
          // Only the first bad beat is reported; later beats are drained to rlast.
          if (beat_bad && !err_flag) begin
            err_flag_n = 1'b1;
            err_addr_n = addr + {20'd0, beat, 3'b000};
          end
          beat_n = beat + 9'd1;
          if (i_rlast) begin
            beat_n = '0;
            if (err_flag || beat_bad) begin
              state_n = S_DONE;
            end else if (wrap) begin
              addr_n  = '0;
              state_n = S_DONE;
            end else begin
              addr_n  = next_addr;
              state_n = S_RAR;
            end
          end
        end
      end
      S_DONE: begin
        if (i_start) begin
          err_flag_n = 1'b0;
          err_addr_n = '0;
          addr_n     = '0;
          beat_n     = '0;
          state_n    = S_WAW;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Channel strobes and status decoded purely from registered state.
  always_comb begin
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_busy      = 1'b1;
    o_init_done = 1'b0;
    case (state)
      S_IDLE: o_busy = 1'b0;
      S_WAW:  o_awvalid = 1'b1;
      S_WDAT: o_wvalid = 1'b1;
      S_WRSP: o_bready = 1'b1;
      S_RAR:  o_arvalid = 1'b1;
      S_RDAT: o_rready = 1'b1;
      S_DONE: begin
        o_busy      = 1'b0;
        o_init_done = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  assign o_init_error = o_init_done && err_flag;
  assign o_err_addr   = err_addr;

  assign o_awid    = '0;
  assign o_awaddr  = addr;
  assign o_awlen   = 8'(BURST_BEATS - 1);
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;

  assign o_wdata = FILL_PATTERN;
  assign o_wstrb = 8'hFF;
  assign o_wlast = (state == S_WDAT) && (beat == LAST_BEAT);

  assign o_arid    = '0;
  assign o_araddr  = addr;
  assign o_arlen   = 8'(BURST_BEATS - 1);
  assign o_arsize  = 3'd3;
  assign o_arburst = 2'b01;

endmodule

// File: tb/tb_axi_ram_init_ctrl.sv
// Purpose: bench for axi_ram_init_ctrl with a randomly stalling AXI slave and a burst-level expectation model.
// Latency: runs whole fill/verify sequences and checks the transaction lists and status at the end.
// Backpressure: slave readies/valids are randomised when stalling is enabled; protocol rules are checked every cycle.
module tb_axi_ram_init_ctrl;

  localparam logic [31:0] RAM   = 32'h400;
  localparam int          BEATS = 16;
  localparam logic [31:0] BB    = 32'(BEATS * 8);
  localparam int          NB    = 32'(RAM / BB);
  localparam logic [63:0] PAT   = 64'h0;
  localparam int          BUDGET = 6000;

  logic        clk, rstn, i_start;
  logic        busy, done, error;
  logic [31:0] err_addr;
  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;

  int checks = 0;
  int failures = 0;

  // slave configuration and bookkeeping
  bit          stall_en;
  int          bresp_err_burst;
  bit          corrupt_en;
  logic [31:0] corrupt_addr;
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  int          prot_err, w_beats_total, r_beats_total, w_beat, wburst_idx, r_beat;
  bit          w_open, b_pending, b_hs, r_active, r_hs;
  logic [1:0]  b_resp_pend;
  logic [31:0] r_base;
  bit          aw_pend, w_pend, ar_pend;
  logic [31:0] aw_pend_addr, ar_pend_addr;
  logic [63:0] w_pend_data;
  logic        w_pend_last;

  axi_ram_init_ctrl #(.RAM_SIZE(RAM)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start),
    .o_busy(busy), .o_init_done(done), .o_init_error(error), .o_err_addr(err_addr),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AXI slave: everything is decided on the falling edge, so a handshake seen here completes at the next rising edge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        w_open = 0; b_pending = 0; b_hs = 0; r_active = 0; r_hs = 0; w_beat = 0; r_beat = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        continue;
      end
      // write response
      if (b_hs) begin bvalid = 0; b_hs = 0; end
      if (!bvalid && b_pending) begin bvalid = 1; bresp = b_resp_pend; b_pending = 0; end
      if (bvalid && bready) b_hs = 1;
      // read data
      if (r_hs) begin
        r_hs = 0; r_beat++; r_beats_total++; rvalid = 0;
        if (r_beat == BEATS) r_active = 0;
      end
      if (r_active && !rvalid) rvalid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rvalid) begin
        rdata = (corrupt_en && (r_base + 32'(r_beat * 8)) == corrupt_addr) ? 64'hDEADBEEF_0BADF00D : PAT;
        rlast = (r_beat == BEATS - 1);
        rresp = 2'b00;
        if (rready) r_hs = 1;
      end
      // write address
      if (aw_pend && !(awvalid && awaddr == aw_pend_addr)) prot_err++;
      awready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      aw_pend = 0;
      if (awvalid) begin
        if (awready) begin
          if (w_open || b_pending || bvalid || r_active) prot_err++;
          if (awlen != 8'd15 || awsize != 3'd3 || awburst != 2'b01 || awid != 6'd0) prot_err++;
          aw_q.push_back(awaddr); w_open = 1; w_beat = 0;
        end else begin
          aw_pend = 1; aw_pend_addr = awaddr;
        end
      end
      // write data
      if (w_pend && !(wvalid && wdata == w_pend_data && wlast == w_pend_last)) prot_err++;
      wready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      w_pend = 0;
      if (wvalid) begin
        if (wready) begin
          if (!w_open || wdata != PAT || wstrb != 8'hFF || wlast != (w_beat == BEATS - 1)) prot_err++;
          w_beat++; w_beats_total++;
          if (w_beat == BEATS) begin
            w_open = 0; b_pending = 1;
            b_resp_pend = (wburst_idx == bresp_err_burst) ? 2'b10 : 2'b00;
            wburst_idx++;
          end
        end else begin
          w_pend = 1; w_pend_data = wdata; w_pend_last = wlast;
        end
      end
      // read address
      if (ar_pend && !(arvalid && araddr == ar_pend_addr)) prot_err++;
      arready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      ar_pend = 0;
      if (arvalid) begin
        if (arready) begin
          if (w_open || b_pending || bvalid || r_active) prot_err++;
          if (arlen != 8'd15 || arsize != 3'd3 || arburst != 2'b01 || arid != 6'd0) prot_err++;
          ar_q.push_back(araddr); r_active = 1; r_base = araddr; r_beat = 0;
        end else begin
          ar_pend = 1; ar_pend_addr = araddr;
        end
      end
    end
  end

  task automatic run_setup(input bit stall, input int berr, input bit cen, input logic [31:0] caddr);
    stall_en = stall; bresp_err_burst = berr; corrupt_en = cen; corrupt_addr = caddr;
    aw_q.delete(); ar_q.delete();
    prot_err = 0; w_beats_total = 0; r_beats_total = 0; wburst_idx = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk); #1;
      if (done && !busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    run_setup(0, -1, 0, 32'h0);
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000000", {busy, done, error, awvalid, wvalid, bready, arvalid, rready}); end
    checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL reset_err_addr: got %0h expected 0", err_addr); end
    checks++; if ({awaddr, araddr} !== 64'h0) begin failures++; $display("FAIL reset_addr: got %0h/%0h expected 0/0", awaddr, araddr); end
    @(posedge clk); #2 rstn = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_before_first_clk: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_first_clk: got %b expected 1", busy); end
  endtask

  task automatic check_full_run(input string tag);
    checks++; if (aw_q.size() != NB) begin failures++; $display("FAIL %s_aw_count: got %0d expected %0d", tag, aw_q.size(), NB); end
    for (int k = 0; k < NB; k++) begin
      logic [31:0] got;
      got = (k < aw_q.size()) ? aw_q[k] : 32'hFFFF_FFFF;
      checks++; if (got !== 32'(k) * BB) begin failures++; $display("FAIL %s_aw%0d: got %0h expected %0h", tag, k, got, 32'(k) * BB); end
    end
    checks++; if (ar_q.size() != NB) begin failures++; $display("FAIL %s_ar_count: got %0d expected %0d", tag, ar_q.size(), NB); end
    for (int k = 0; k < NB; k++) begin
      logic [31:0] got;
      got = (k < ar_q.size()) ? ar_q[k] : 32'hFFFF_FFFF;
      checks++; if (got !== 32'(k) * BB) begin failures++; $display("FAIL %s_ar%0d: got %0h expected %0h", tag, k, got, 32'(k) * BB); end
    end
    checks++; if ({done, error, busy} !== 3'b100) begin failures++; $display("FAIL %s_status: got done/err/busy=%b expected 100", tag, {done, error, busy}); end
    checks++; if (w_beats_total != NB * BEATS || r_beats_total != NB * BEATS) begin
      failures++; $display("FAIL %s_beats: got w=%0d r=%0d expected %0d", tag, w_beats_total, r_beats_total, NB * BEATS); end
    checks++; if (prot_err != 0) begin failures++; $display("FAIL %s_protocol: got %0d violations expected 0", tag, prot_err); end
  endtask

  task automatic test_ideal();
    bit ok;
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ideal_timeout: got no done expected done within %0d cycles", BUDGET); end
    check_full_run("ideal");
  endtask

  task automatic test_stalls();
    bit ok;
    run_setup(1, -1, 0, 32'h0);
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({done, busy} !== 2'b01) begin failures++; $display("FAIL rerun_done_clear: got done/busy=%b expected 01", {done, busy}); end
    @(negedge clk); i_start = 1'b0;
    repeat (3) begin
      repeat (20) @(negedge clk);
      i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
    end
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: got no done expected done within %0d cycles", BUDGET); end
    check_full_run("stall");
  endtask

  task automatic test_bresp_err();
    bit ok;
    run_setup(0, 2, 0, 32'h0);
    pulse_start();
    wait_done(ok);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("FAIL berr_timeout: got no done expected done"); end
    checks++; if ({done, error, busy} !== 3'b110) begin failures++; $display("FAIL berr_status: got done/err/busy=%b expected 110", {done, error, busy}); end
    checks++; if (err_addr !== 32'(2) * BB) begin failures++; $display("FAIL berr_addr: got %0h expected %0h", err_addr, 32'(2) * BB); end
    checks++; if (aw_q.size() != 3 || ar_q.size() != 0) begin
      failures++; $display("FAIL berr_txn_count: got aw=%0d ar=%0d expected aw=3 ar=0", aw_q.size(), ar_q.size()); end
    checks++; if (prot_err != 0) begin failures++; $display("FAIL berr_protocol: got %0d violations expected 0", prot_err); end
  endtask

  task automatic test_rdata_corrupt();
    bit ok;
    int exp_ar;
    exp_ar = int'(32'h208 / BB) + 1;
    run_setup(1, -1, 1, 32'h208);
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rerr_timeout: got no done expected done"); end
    checks++; if ({done, error} !== 2'b11) begin failures++; $display("FAIL rerr_status: got done/err=%b expected 11", {done, error}); end
    checks++; if (err_addr !== 32'h208) begin failures++; $display("FAIL rerr_addr: got %0h expected 208", err_addr); end
    checks++; if (aw_q.size() != NB || ar_q.size() != exp_ar) begin
      failures++; $display("FAIL rerr_txn_count: got aw=%0d ar=%0d expected aw=%0d ar=%0d", aw_q.size(), ar_q.size(), NB, exp_ar); end
    checks++; if (r_beats_total != exp_ar * BEATS) begin failures++; $display("FAIL rerr_drain: got %0d beats expected %0d", r_beats_total, exp_ar * BEATS); end
    checks++; if (prot_err != 0) begin failures++; $display("FAIL rerr_protocol: got %0d violations expected 0", prot_err); end
  endtask

  task automatic test_reset_midburst();
    bit ok, hit;
    run_setup(0, -1, 0, 32'h0);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk); #1;
      if (aw_q.size() == 2 && w_beat == 5) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL midburst_reach: got no beat 5 of burst 2 expected reached"); end
    @(posedge clk); #2;
    checks++; if (wvalid !== 1'b1 || awaddr !== BB) begin failures++; $display("FAIL midburst_state: got wvalid=%b addr=%0h expected 1/%0h", wvalid, awaddr, BB); end
    rstn = 1'b0;
    #1;
    checks++; if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
      failures++; $display("FAIL midburst_reset_ctrl: got %b expected 00000000", {busy, done, error, awvalid, wvalid, bready, arvalid, rready}); end
    checks++; if ({awaddr, araddr, err_addr} !== 96'h0) begin failures++; $display("FAIL midburst_reset_addr: got %0h/%0h/%0h expected 0", awaddr, araddr, err_addr); end
    repeat (2) @(negedge clk);
    run_setup(0, -1, 0, 32'h0);
    @(posedge clk); #2 rstn = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL midburst_timeout: got no done expected done"); end
    check_full_run("after_reset");
  endtask

  initial begin
    rstn = 1'b0;
    i_start = 1'b0;
    test_reset();
    test_ideal();
    test_stalls();
    test_bresp_err();
    test_rdata_corrupt();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
